nn_inference_acc_relu: RTL and testbench



---
 rtl/nn_inference_acc_relu.sv | 155 +++++++++++++++
 tb/tb_nn_inference_acc_relu.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_inference_acc_relu.sv
`default_nettype none
// ============================================================================
// Module   : nn_inference_acc_relu
// Purpose  : Neuron accumulator for the nn_inference datapath. It preloads a
//            Q8.8 bias, accumulates a stream of signed multiplier products
//            with saturation, then rescales, applies ReLU and clamps the
//            result to a 16-bit Q8.8 activation on a valid/ready output.
// Ports    : clk         - clock, all logic on rising edge
//            reset       - synchronous, active-high reset
//            start       - begin new neuron (IDLE, or HOLD with dout_ready)
//            bias        - signed Q8.8 bias, captured with an accepted start
//            prod_valid  - prod is valid this cycle
//            prod        - signed product from the multiplier
//            prod_last   - marks the final product of the neuron
//            in_ready    - product accepted when prod_valid & in_ready
//            busy        - state is not IDLE
//            dout_valid  - activation available
//            dout        - activation, Q8.8, 0 .. 2^(OUT_WIDTH-1)-1
//            dout_ready  - consumer accepts dout when dout_valid & dout_ready
// Revision : 1.0 - initial release
// ============================================================================
module nn_inference_acc_relu #(
    parameter int PROD_WIDTH = 27,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [OUT_WIDTH-1:0]  bias,
    input  logic                  prod_valid,
    input  logic [PROD_WIDTH-1:0] prod,
    input  logic                  prod_last,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  dout_valid,
    output logic [OUT_WIDTH-1:0]  dout,
    input  logic                  dout_ready
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCUM  = 2'd1;
    localparam logic [1:0] c_FINISH = 2'd2;
    localparam logic [1:0] c_HOLD   = 2'd3;

    localparam logic signed [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0]        c_ACT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

    logic [1:0]                  r_state;
    logic [1:0]                  w_state_nxt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [OUT_WIDTH-1:0]        r_dout;

    logic                        w_load_bias;
    logic                        w_acc_en;
    logic                        w_finish;
    logic signed [ACC_WIDTH-1:0] w_bias_ext;
    logic signed [ACC_WIDTH:0]   w_sum;
    logic signed [ACC_WIDTH-1:0] w_sat;
    logic signed [ACC_WIDTH-1:0] w_shift;
    logic [OUT_WIDTH-1:0]        w_act;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (start) w_state_nxt = c_ACCUM;
            c_ACCUM:  if (prod_valid && prod_last) w_state_nxt = c_FINISH;
            c_FINISH: w_state_nxt = c_HOLD;
            c_HOLD:   if (dout_ready) w_state_nxt = start ? c_ACCUM : c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode. Every output is a pure decode of the state
    // register, so in_ready never depends combinationally on an input and
    // can drive the multiplier clock enable directly.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready    = (r_state == c_ACCUM);
        busy        = (r_state != c_IDLE);
        dout_valid  = (r_state == c_HOLD);
        w_finish    = (r_state == c_FINISH);
        w_acc_en    = (r_state == c_ACCUM) && prod_valid;
        // A start is only honoured in IDLE, or in HOLD together with the
        // output handshake so a new neuron follows without an idle bubble.
        w_load_bias = start && ((r_state == c_IDLE) ||
                                ((r_state == c_HOLD) && dout_ready));
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // Bias is Q8.8; the products are Q.16, so align the bias before preload.
    assign w_bias_ext = $signed({{(ACC_WIDTH-OUT_WIDTH){bias[OUT_WIDTH-1]}}, bias}) <<< FRAC_SHIFT;

    // One guard bit is enough to detect overflow of a single add.
    assign w_sum = {r_acc[ACC_WIDTH-1], r_acc}
                 + {{(ACC_WIDTH+1-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

    always_comb begin
        w_sat = w_sum[ACC_WIDTH-1:0];
        if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1]) begin
            w_sat = w_sum[ACC_WIDTH] ? c_ACC_MIN : c_ACC_MAX;
        end
    end

    // Arithmetic shift floors toward -inf, then ReLU and clamp.
    assign w_shift = r_acc >>> FRAC_SHIFT;

    always_comb begin
        w_act = w_shift[OUT_WIDTH-1:0];
        if (w_shift[ACC_WIDTH-1]) begin
            w_act = '0;
        end else if (w_shift > $signed({{(ACC_WIDTH-OUT_WIDTH){1'b0}}, c_ACT_MAX})) begin
            w_act = c_ACT_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc  <= '0;
            r_dout <= '0;
        end else begin
            if (w_load_bias) begin
                r_acc <= w_bias_ext;
            end else if (w_acc_en) begin
                r_acc <= w_sat;
            end
            if (w_finish) begin
                r_dout <= w_act;
            end
        end
    end

    assign dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_nn_inference_acc_relu.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_inference_acc_relu
// Purpose  : Self-checking bench for nn_inference_acc_relu. A queue-based
//            neuron model predicts each activation; a per-cycle monitor
//            compares DUT outputs, output latency and hold stability.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_inference_acc_relu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] bias;
    logic        prod_valid;
    logic [26:0] prod;
    logic        prod_last;
    logic        in_ready;
    logic        busy;
    logic        dout_valid;
    logic [15:0] dout;
    logic        dout_ready;

    int          checks = 0;
    int          errors = 0;
    int          n_results = 0;
    logic [31:0] cyc = 0;
    logic [31:0] t_last = 0;
    bit          pending = 0;
    logic [15:0] last_out = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    nn_inference_acc_relu #(
        .PROD_WIDTH(27),
        .ACC_WIDTH (32),
        .OUT_WIDTH (16),
        .FRAC_SHIFT(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bias      (bias),
        .prod_valid(prod_valid),
        .prod      (prod),
        .prod_last (prod_last),
        .in_ready  (in_ready),
        .busy      (busy),
        .dout_valid(dout_valid),
        .dout      (dout),
        .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Neuron model: plain integer arithmetic with clamping.
    function automatic logic [15:0] model_neuron(input int b, input int ps[$]);
        longint acc;
        longint r;
        acc = longint'(b) * 256;
        foreach (ps[i]) begin
            acc = acc + longint'(ps[i]);
            if (acc > 64'sd2147483647) acc = 64'sd2147483647;
            else if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        end
        r = acc >>> 8;
        if (r < 0) return 16'h0000;
        if (r > 32767) return 16'h7FFF;
        return r[15:0];
    endfunction

    // Monitor: every negedge, outside reset.
    always @(negedge clk) begin
        if (reset) begin
            pending = 0;
        end else begin
            check("ready_and_valid", {31'd0, in_ready & dout_valid}, 32'd0);
            check("busy_cover", {31'd0, (in_ready | dout_valid) & ~busy}, 32'd0);
            if (prod_valid && in_ready && prod_last) t_last = cyc;
            if (dout_valid) begin
                if (!pending) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        check("dout", {16'd0, dout}, {16'd0, exp_q.pop_front()});
                    end
                    check("latency", cyc - t_last, 32'd2);
                    last_out = dout;
                    got_q.push_back(dout);
                    n_results++;
                end else begin
                    check("dout_hold", {16'd0, dout}, {16'd0, last_out});
                end
                pending = !dout_ready;
            end else begin
                pending = 0;
            end
        end
    end

    task automatic do_start(input int b);
        bias  = b[15:0];
        start = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (in_ready) break;
        end
        check("start_accepted", {31'd0, in_ready}, 32'd1);
        start = 1'b0;
    endtask

    task automatic feed(input int ps[$], input bit with_last);
        int p;
        for (int i = 0; i < ps.size(); i++) begin
            p          = ps[i];
            prod_valid = 1'b1;
            prod       = p[26:0];
            prod_last  = with_last && (i == ps.size() - 1);
            check("busy_in_accum", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic run_neuron(input int b, input int ps[$]);
        exp_q.push_back(model_neuron(b, ps));
        do_start(b);
        feed(ps, 1'b1);
    endtask

    task automatic wait_results(input int target);
        for (int k = 0; k < 300; k++) begin
            if (n_results >= target) break;
            @(negedge clk);
        end
        check("result_arrived", {31'd0, n_results >= target}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ps[$];
        int a_ps[$];
        int b_ps[$];
        int base;
        int p;

        reset      = 1'b1;
        start      = 1'b0;
        bias       = '0;
        prod_valid = 1'b0;
        prod       = '0;
        prod_last  = 1'b0;
        dout_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", {16'd0, dout}, 32'd0);
        check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic accumulation
        ps = '{65536, 32768};
        run_neuron(256, ps);
        wait_results(1);
        check("basic_literal", {16'd0, last_out}, 32'h0280);
        repeat (3) @(posedge clk);
        #1;
        check("dout_kept_after_hs", {16'd0, dout}, 32'h0280);
        check("idle_after_hs", {31'd0, busy}, 32'd0);

        // ReLU
        ps = '{-65536};
        run_neuron(0, ps);
        wait_results(2);
        check("relu_literal", {16'd0, last_out}, 32'h0000);

        // Positive saturation
        ps.delete();
        for (int i = 0; i < 40; i++) ps.push_back(32'h03FF_FFFF);
        run_neuron(32767, ps);
        wait_results(3);
        check("sat_hi_literal", {16'd0, last_out}, 32'h7FFF);
        check("acc_clamp_hi", dut.r_acc, 32'h7FFF_FFFF);

        // Negative saturation
        ps.delete();
        for (int i = 0; i < 40; i++) ps.push_back(-67108864);
        run_neuron(-32768, ps);
        wait_results(4);
        check("sat_lo_literal", {16'd0, last_out}, 32'h0000);
        check("acc_clamp_lo", dut.r_acc, 32'h8000_0000);

        // Backpressure: hold, ignored products, then start with handshake
        dout_ready = 1'b0;
        ps = '{768};
        run_neuron(16, ps);
        wait_results(5);
        check("bp_literal", {16'd0, last_out}, 32'h0013);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            p          = 32'h0001_0000 * (i + 1);
            prod_valid = 1'b1;
            prod       = p[26:0];
            prod_last  = 1'b1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_valid_held", {31'd0, dout_valid}, 32'd1);
            check("bp_dout_held", {16'd0, dout}, 32'h0013);
        end
        @(posedge clk); #1;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        ps = '{0};
        exp_q.push_back(model_neuron(512, ps));
        bias       = 16'h0200;
        start      = 1'b1;
        dout_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("bp_accum_next", {31'd0, in_ready}, 32'd1);
        feed(ps, 1'b1);
        wait_results(6);
        check("bp_new_literal", {16'd0, last_out}, 32'h0200);

        // Reset mid-operation
        @(posedge clk); #1;
        ps = '{4096, 4096, 4096};
        do_start(80);
        feed(ps, 1'b0);
        prod_valid = 1'b1;
        prod       = 27'd256;
        prod_last  = 1'b1;
        start      = 1'b1;
        reset      = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        check("mid_rst_dout", {16'd0, dout}, 32'd0);
        reset      = 1'b0;
        start      = 1'b0;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        @(posedge clk); #1;
        ps = '{256};
        run_neuron(0, ps);
        wait_results(7);
        check("post_rst_literal", {16'd0, last_out}, 32'h0001);

        // Back-to-back neurons, dout_ready tied high
        a_ps = '{32'h1234, -2048, 32'h20000, 7};
        b_ps = '{1024, 1024, 1024, 256};
        base = got_q.size();
        run_neuron(3, a_ps);
        run_neuron(-2, b_ps);
        wait_results(9);
        if (got_q.size() >= base + 2) begin
            check("b2b_a_literal", {16'd0, got_q[base]}, 32'h020D);
            check("b2b_b_literal", {16'd0, got_q[base+1]}, 32'h000B);
        end else begin
            check("b2b_outputs", got_q.size(), base + 2);
        end
        repeat (4) @(posedge clk);
        #1;
        check("exp_queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
